// File: rtl/pe_pkg.sv
// Shared types for the multi-stationary PE slice.
// Mode encodings, FSM states and counter width.
package pe_pkg;

  typedef enum logic [1:0] {
    MODE_IS = 2'b00,
    MODE_WS = 2'b01,
    MODE_OS = 2'b10
  } mode_e;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_LOAD,
    ST_COMPUTE,
    ST_FLUSH,
    ST_DRAIN
  } state_e;

  localparam int GATE_CNT_W = 16;

endpackage

// File: rtl/pe_mac_lane.sv
// One MAC lane: gate check, multiplier pipe, psum delay, OS accumulator.
// Zero gating compiled in only with PE_ZERO_GATING_EN.
module pe_mac_lane
  import pe_pkg::*;
#(
  parameter int WIDTH_A   = 16,
  parameter int WIDTH_B   = 16,
  parameter int WIDTH_MAC = 48,
  parameter int WIDTH_T   = 4,
  parameter int STAGE     = 1,
  parameter int SIGNED    = 1
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 accept,
  input  logic                 load,
  input  logic                 clr,
  input  mode_e                mode,
  input  logic [WIDTH_T-1:0]   thres,
  input  logic [WIDTH_A-1:0]   act,
  input  logic [WIDTH_B-1:0]   wei,
  input  logic [WIDTH_MAC-1:0] psum_in,
  output logic [WIDTH_MAC-1:0] sum,
  output logic                 sum_valid,
  output logic [WIDTH_MAC-1:0] acc,
  output logic                 busy,
  output logic                 gated
);

  localparam int WP = WIDTH_A + WIDTH_B;

  logic [WIDTH_A-1:0]   stat_act_q, a_sel, a_q;
  logic [WIDTH_B-1:0]   stat_wei_q, b_sel, b_q;
  logic [WIDTH_MAC-1:0] ps_q, acc_q, ps_last, pext;
  logic [WP-1:0]        ax, bx, pf, p0, p_last;
  logic                 g_q, v0_q, gate;
  logic                 sa, sb, sp, v_last, stg_busy;

  always_comb begin
    a_sel = act;
    b_sel = wei;
    unique case (1'b1)
      mode == MODE_IS: a_sel = stat_act_q;
      mode == MODE_WS: b_sel = stat_wei_q;
      default: ;
    endcase
  end

`ifdef PE_ZERO_GATING_EN
  logic [WIDTH_A-1:0] abs_a;
  logic [WIDTH_B-1:0] abs_b;
  assign abs_a = (SIGNED != 0 && a_sel[WIDTH_A-1]) ? -a_sel : a_sel;
  assign abs_b = (SIGNED != 0 && b_sel[WIDTH_B-1]) ? -b_sel : b_sel;
  // |x| < 2^t  <=>  (|x| >> t) == 0
  assign gate = ((abs_a >> thres) == '0) || ((abs_b >> thres) == '0);
`else
  logic unused_thres;
  assign unused_thres = ^thres;
  assign gate = 1'b0;
`endif

  assign gated = accept & gate;

  always_ff @(posedge clk) begin
    if (rst) begin
      stat_act_q <= '0;
      stat_wei_q <= '0;
      a_q        <= '0;
      b_q        <= '0;
      ps_q       <= '0;
      g_q        <= 1'b0;
      v0_q       <= 1'b0;
    end else begin
      v0_q <= accept;
      if (load && mode == MODE_IS) stat_act_q <= act;
      if (load && mode == MODE_WS) stat_wei_q <= wei;
      if (accept) begin
        g_q  <= gate;
        ps_q <= psum_in;
        if (!gate) begin
          a_q <= a_sel;
          b_q <= b_sel;
        end
      end
    end
  end

  // Low WP bits of the extended product are exact for both signednesses
  assign sa = (SIGNED != 0) && a_q[WIDTH_A-1];
  assign sb = (SIGNED != 0) && b_q[WIDTH_B-1];
  assign ax = {{WIDTH_B{sa}}, a_q};
  assign bx = {{WIDTH_A{sb}}, b_q};
  assign pf = ax * bx;
  assign p0 = g_q ? '0 : pf;

  generate
    if (STAGE == 0) begin : g_nopipe
      assign p_last   = p0;
      assign ps_last  = ps_q;
      assign v_last   = v0_q;
      assign stg_busy = 1'b0;
    end else begin : g_pipe
      logic [WP-1:0]        p_r  [STAGE];
      logic [WIDTH_MAC-1:0] ps_r [STAGE];
      logic [STAGE-1:0]     v_r;
      always_ff @(posedge clk) begin
        if (rst) begin
          v_r <= '0;
          for (int k = 0; k < STAGE; k++) begin
            p_r[k]  <= '0;
            ps_r[k] <= '0;
          end
        end else begin
          v_r[0]  <= v0_q;
          p_r[0]  <= p0;
          ps_r[0] <= ps_q;
          for (int k = 1; k < STAGE; k++) begin
            v_r[k]  <= v_r[k-1];
            p_r[k]  <= p_r[k-1];
            ps_r[k] <= ps_r[k-1];
          end
        end
      end
      assign p_last   = p_r[STAGE-1];
      assign ps_last  = ps_r[STAGE-1];
      assign v_last   = v_r[STAGE-1];
      assign stg_busy = |v_r;
    end
  endgenerate

  assign sp   = (SIGNED != 0) && p_last[WP-1];
  assign pext = {{(WIDTH_MAC-WP){sp}}, p_last};

  always_ff @(posedge clk) begin
    if (rst || clr) begin
      acc_q <= '0;
    end else if (v_last && mode == MODE_OS) begin
      acc_q <= acc_q + pext;
    end
  end

  assign sum       = ps_last + pext;
  assign sum_valid = v_last;
  assign acc       = acc_q;
  assign busy      = v0_q | stg_busy;

endmodule

// File: rtl/processing_element_ms.sv
// Multi-stationary multi-lane systolic PE (IS/WS/OS).
// Optional zero gating: define PE_ZERO_GATING_EN.
module processing_element_ms
  import pe_pkg::*;
#(
  parameter int LANES     = 4,
  parameter int WIDTH_A   = 16,
  parameter int WIDTH_B   = 16,
  parameter int WIDTH_MAC = 48,
  parameter int WIDTH_T   = 4,
  parameter int STAGE     = 1,
  parameter int SIGNED    = 1
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic [1:0]                 mode,
  input  logic                       start,
  input  logic                       stat_load,
  input  logic                       finish,
  input  logic                       in_valid,
  input  logic [LANES*WIDTH_A-1:0]   act_in,
  input  logic [LANES*WIDTH_B-1:0]   wei_in,
  input  logic [LANES*WIDTH_MAC-1:0] psum_in,
  input  logic                       psum_in_valid,
  input  logic [WIDTH_T-1:0]         thres,
  output logic [LANES*WIDTH_A-1:0]   act_out,
  output logic [LANES*WIDTH_B-1:0]   wei_out,
  output logic                       valid_out,
  output logic [LANES*WIDTH_MAC-1:0] psum_out,
  output logic                       psum_out_valid,
  output logic                       busy,
  output logic                       err,
  output logic [GATE_CNT_W-1:0]      gate_cnt
);

  state_e state;
  mode_e  mode_q, m_norm;
  logic   drain_first;
  logic   accept, load, clr;
  logic   drain_own, drain_fwd, emit;

  logic [LANES-1:0]           lane_busy, lane_vld, lane_gated;
  logic [LANES*WIDTH_MAC-1:0] lane_sum, lane_acc;

  assign m_norm    = mode[1] ? MODE_OS : mode_e'(mode);
  assign accept    = (state == ST_COMPUTE) && in_valid;
  assign load      = (state == ST_LOAD) && stat_load;
  assign drain_own = (state == ST_DRAIN) && drain_first;
  assign drain_fwd = (state == ST_DRAIN) && !drain_first;
  assign clr       = drain_own || ((state == ST_IDLE) && start && mode[1]);
  assign emit      = (|lane_vld) && (mode_q != MODE_OS);
  assign busy      = (state != ST_IDLE);

  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= ST_IDLE;
      mode_q      <= MODE_IS;
      drain_first <= 1'b0;
    end else begin
      unique case (state)
        ST_IDLE: if (start) begin
          mode_q      <= m_norm;
          drain_first <= 1'b0;
          state       <= (m_norm == MODE_OS) ? ST_COMPUTE : ST_LOAD;
        end
        ST_LOAD:    if (stat_load) state <= ST_COMPUTE;
        ST_COMPUTE: if (finish) state <= ST_FLUSH;
        ST_FLUSH: if (!(|lane_busy)) begin
          if (mode_q == MODE_OS) begin
            state       <= ST_DRAIN;
            drain_first <= 1'b1;
          end else begin
            state <= ST_IDLE;
          end
        end
        ST_DRAIN: begin
          if (drain_first) drain_first <= 1'b0;
          else if (!psum_in_valid) state <= ST_IDLE;
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      act_out   <= '0;
      wei_out   <= '0;
      valid_out <= 1'b0;
    end else begin
      act_out   <= act_in;
      wei_out   <= wei_in;
      valid_out <= in_valid;
    end
  end

  // Own accumulator wins over an upstream word on the first drain beat
  always_ff @(posedge clk) begin
    if (rst) begin
      psum_out       <= '0;
      psum_out_valid <= 1'b0;
      err            <= 1'b0;
    end else begin
      unique case (1'b1)
        drain_own: begin
          psum_out       <= lane_acc;
          psum_out_valid <= 1'b1;
          if (psum_in_valid) err <= 1'b1;
        end
        drain_fwd: begin
          psum_out       <= psum_in;
          psum_out_valid <= psum_in_valid;
        end
        emit: begin
          psum_out       <= lane_sum;
          psum_out_valid <= 1'b1;
        end
        default: psum_out_valid <= 1'b0;
      endcase
    end
  end

  for (genvar i = 0; i < LANES; i++) begin : g_lane
    pe_mac_lane #(
      .WIDTH_A  (WIDTH_A),
      .WIDTH_B  (WIDTH_B),
      .WIDTH_MAC(WIDTH_MAC),
      .WIDTH_T  (WIDTH_T),
      .STAGE    (STAGE),
      .SIGNED   (SIGNED)
    ) u_lane (
      .clk      (clk),
      .rst      (rst),
      .accept   (accept),
      .load     (load),
      .clr      (clr),
      .mode     (mode_q),
      .thres    (thres),
      .act      (act_in[i*WIDTH_A +: WIDTH_A]),
      .wei      (wei_in[i*WIDTH_B +: WIDTH_B]),
      .psum_in  (psum_in[i*WIDTH_MAC +: WIDTH_MAC]),
      .sum      (lane_sum[i*WIDTH_MAC +: WIDTH_MAC]),
      .sum_valid(lane_vld[i]),
      .acc      (lane_acc[i*WIDTH_MAC +: WIDTH_MAC]),
      .busy     (lane_busy[i]),
      .gated    (lane_gated[i])
    );
  end

`ifdef PE_ZERO_GATING_EN
  logic [GATE_CNT_W-1:0] gcnt;
  logic [GATE_CNT_W:0]   gsum;

  always_comb begin
    gcnt = '0;
    for (int i = 0; i < LANES; i++) begin
      gcnt = gcnt + GATE_CNT_W'(lane_gated[i]);
    end
  end

  assign gsum = {1'b0, gate_cnt} + {1'b0, gcnt};

  always_ff @(posedge clk) begin
    if (rst) gate_cnt <= '0;
    else gate_cnt <= gsum[GATE_CNT_W] ? '1 : gsum[GATE_CNT_W-1:0];
  end
`else
  logic unused_gated;
  assign unused_gated = ^lane_gated;
  assign gate_cnt     = '0;
`endif

endmodule

// File: tb/tb_processing_element_ms.sv
// Scoreboard bench for processing_element_ms (LANES=4, STAGE=1, signed).
// Gating expectations follow PE_ZERO_GATING_EN.
module tb_processing_element_ms;

  logic         clk, rst;
  logic [1:0]   mode;
  logic         start, stat_load, finish, in_valid, psum_in_valid;
  logic [63:0]  act_in, wei_in, act_out, wei_out;
  logic [191:0] psum_in, psum_out;
  logic [3:0]   thres;
  logic         valid_out, psum_out_valid, busy, err;
  logic [15:0]  gate_cnt;

  int checks = 0;
  int failures = 0;
  logic [191:0] exp_q[$];

  processing_element_ms dut (
    .clk(clk), .rst(rst), .mode(mode), .start(start),
    .stat_load(stat_load), .finish(finish), .in_valid(in_valid),
    .act_in(act_in), .wei_in(wei_in), .psum_in(psum_in),
    .psum_in_valid(psum_in_valid), .thres(thres),
    .act_out(act_out), .wei_out(wei_out), .valid_out(valid_out),
    .psum_out(psum_out), .psum_out_valid(psum_out_valid),
    .busy(busy), .err(err), .gate_cnt(gate_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [63:0] pa(input int a0, a1, a2, a3);
    return {a3[15:0], a2[15:0], a1[15:0], a0[15:0]};
  endfunction

  function automatic logic [191:0] pk(input longint p0, p1, p2, p3);
    return {p3[47:0], p2[47:0], p1[47:0], p0[47:0]};
  endfunction

  task automatic chk(input string nm, input logic [191:0] got,
                     input logic [191:0] want);
    checks++;
    if (got !== want) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", nm, got, want);
    end
  endtask

  always @(negedge clk) begin
    if (!rst && psum_out_valid) begin
      if (exp_q.size() == 0) begin
        checks++;
        failures++;
        $display("FAIL sb_unexpected: got %0h expected none", psum_out);
      end else begin
        chk("sb_psum", psum_out, exp_q.pop_front());
      end
    end
  end

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_idle(input string nm);
    int n = 0;
    while (busy && n < 100) begin
      cyc();
      n++;
    end
    chk(nm, {191'd0, busy}, 192'd0);
  endtask

  task automatic idle_inputs();
    start = 0; stat_load = 0; finish = 0; in_valid = 0;
    psum_in_valid = 0; psum_in = '0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

  initial begin
    rst = 1; mode = 2'b00; thres = 4'd0;
    act_in = '0; wei_in = '0;
    idle_inputs();
    cyc(); cyc();
    rst = 0;
    chk("rst_busy", {191'd0, busy}, 192'd0);
    chk("rst_psum", psum_out, 192'd0);
    chk("rst_pvalid", {191'd0, psum_out_valid}, 192'd0);
    chk("rst_err", {191'd0, err}, 192'd0);
    chk("rst_act_out", {128'd0, act_out}, 192'd0);
    chk("rst_gate_cnt", {176'd0, gate_cnt}, 192'd0);

    // IS: stationary activations, latency check
    mode = 2'b00; start = 1;
    cyc();
    start = 0; stat_load = 1;
    act_in = pa(-3, 2, 0, -1);
    cyc();
    stat_load = 0;
    in_valid = 1;
    wei_in  = pa(5, -4, 9, 1000);
    psum_in = pk(100, 1, -7, 0);
    exp_q.push_back(pk(85, -7, -7, -1000));
    cyc();
    in_valid = 0; finish = 1;
    chk("is_lat0", {191'd0, psum_out_valid}, 192'd0);
    chk("fwd_valid", {191'd0, valid_out}, 192'd1);
    chk("fwd_act", {128'd0, act_out}, {128'd0, pa(-3, 2, 0, -1)});
    chk("fwd_wei", {128'd0, wei_out}, {128'd0, pa(5, -4, 9, 1000)});
    cyc();
    finish = 0;
    chk("is_lat1", {191'd0, psum_out_valid}, 192'd0);
    cyc();
    chk("is_lat2", {191'd0, psum_out_valid}, 192'd1);
    wait_idle("is_idle");

    // WS: stationary weights, 4 back-to-back beats, finish on last
    mode = 2'b01; start = 1;
    cyc();
    start = 0; stat_load = 1;
    wei_in = pa(7, -32768, 1, -1);
    cyc();
    stat_load = 0;
    for (int k = 1; k <= 4; k++) begin
      in_valid = 1;
      finish = (k == 4);
      act_in  = pa(k, -32768, -k, k);
      psum_in = pk(0, 0, -1, 0);
      exp_q.push_back(pk(7 * k, 1073741824, -k - 1, -k));
      cyc();
    end
    in_valid = 0; finish = 0;
    wait_idle("ws_idle");

    // OS: accumulate 3 beats then drain with forwarded words
    mode = 2'b10; start = 1;
    cyc();
    start = 0;
    for (int k = 1; k <= 3; k++) begin
      in_valid = 1;
      finish = (k == 3);
      act_in = pa(2, -5, 32767, 1);
      wei_in = pa(3, 7, 32767, -1);
      cyc();
    end
    in_valid = 0; finish = 0;
    exp_q.push_back(pk(18, -105, 64'd3221028867, -3));
    begin
      int n = 0;
      while (!psum_out_valid && n < 50) begin
        cyc();
        n++;
      end
      chk("os_own_seen", {191'd0, psum_out_valid}, 192'd1);
    end
    psum_in_valid = 1;
    psum_in = pk(9, 19, 29, 39);
    exp_q.push_back(pk(9, 19, 29, 39));
    cyc();
    psum_in = pk(11, 21, 31, 41);
    exp_q.push_back(pk(11, 21, 31, 41));
    cyc();
    psum_in_valid = 0;
    cyc();
    chk("os_idle", {191'd0, busy}, 192'd0);
    chk("os_err", {191'd0, err}, 192'd0);

    // OS drain collision on first drain cycle
    mode = 2'b11; start = 1;
    cyc();
    start = 0;
    in_valid = 1; finish = 1;
    act_in = pa(4, 1, 1, 1);
    wei_in = pa(5, 2, 3, -4);
    cyc();
    in_valid = 0; finish = 0;
    exp_q.push_back(pk(20, 2, 3, -4));
    cyc(); cyc(); cyc();
    psum_in_valid = 1;
    psum_in = pk(77, 77, 77, 77);
    cyc();
    psum_in_valid = 0;
    chk("coll_err", {191'd0, err}, 192'd1);
    cyc();
    chk("coll_idle", {191'd0, busy}, 192'd0);
    chk("coll_err_sticky", {191'd0, err}, 192'd1);

    // Abort with two beats in flight
    mode = 2'b00; start = 1;
    cyc();
    start = 0; stat_load = 1;
    act_in = pa(1, 1, 1, 1);
    cyc();
    stat_load = 0; in_valid = 1;
    wei_in = pa(2, 2, 2, 2);
    psum_in = '0;
    cyc(); cyc();
    rst = 1;
    cyc();
    rst = 0; in_valid = 0;
    chk("abort_busy", {191'd0, busy}, 192'd0);
    chk("abort_psum", psum_out, 192'd0);
    chk("abort_pvalid", {191'd0, psum_out_valid}, 192'd0);
    chk("abort_err", {191'd0, err}, 192'd0);
    chk("abort_act_out", {128'd0, act_out}, 192'd0);
    chk("abort_wei_out", {128'd0, wei_out}, 192'd0);
    chk("abort_vout", {191'd0, valid_out}, 192'd0);
    chk("abort_gate_cnt", {176'd0, gate_cnt}, 192'd0);
    for (int k = 0; k < 4; k++) begin
      cyc();
      chk("abort_quiet", {191'd0, psum_out_valid}, 192'd0);
    end

    // Zero gating with thres = 2
    thres = 4'd2;
    mode = 2'b10; start = 1;
    cyc();
    start = 0; in_valid = 1;
    act_in = pa(3, 8, 8, 8);
    wei_in = pa(100, 8, 8, 8);
    cyc();
`ifdef PE_ZERO_GATING_EN
    chk("gate_cnt1", {176'd0, gate_cnt}, 192'd1);
`else
    chk("gate_cnt1", {176'd0, gate_cnt}, 192'd0);
`endif
    finish = 1;
    act_in = pa(4, 8, 8, 8);
    cyc();
    in_valid = 0; finish = 0;
`ifdef PE_ZERO_GATING_EN
    chk("gate_cnt2", {176'd0, gate_cnt}, 192'd1);
    exp_q.push_back(pk(400, 128, 128, 128));
`else
    chk("gate_cnt2", {176'd0, gate_cnt}, 192'd0);
    exp_q.push_back(pk(700, 128, 128, 128));
`endif
    wait_idle("gate_idle");

    cyc(); cyc();
    chk("sb_empty", {160'd0, 32'(exp_q.size())}, 192'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
